// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder (target side) for core load/store requests.
// One request at a time is accepted over a valid/ready request channel. After a
// fixed LATENCY the B/H/W/D access is performed on an internal 64-bit-wide array,
// and the load result (sign/zero-extended) or store completion is returned over a
// valid/ready response channel.
//
// Parameters:
//   BASE    - byte address mapped to word 0 of the array
//   DEPTH   - number of 64-bit words (power of two, >= 2)
//   LATENCY - edges from accept edge (inclusive) to the edge that raises resp_valid (>= 1)
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   req_valid/req_ready, req_wen, req_addr, req_size (0=B,1=H,2=W,3=D),
//   req_unsigned, req_wdata (LSB-aligned)                       - request channel
//   resp_valid/resp_ready, resp_rdata, resp_err                 - response channel
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   - misaligned H/W/D accesses fault (resp_err=1, no write)
//   undefined - misaligned low offset bits are cleared and the access proceeds
module dmem_responder #(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          commit;

  logic          lat_wen, lat_uns;
  logic [1:0]    lat_size;
  logic [63:0]   lat_addr, lat_wdata;

  logic          acc_wen, acc_uns;
  logic [1:0]    acc_size;
  logic [63:0]   acc_addr, acc_wdata;

  logic [63:0]   off;
  logic [2:0]    lane;
  logic [IW-1:0] idx;
  logic          range_err, acc_err;
  logic [7:0]    be_base, be;
  logic [63:0]   wword, rshift, ldata;

  logic [63:0]   mem [DEPTH];

  // With LATENCY=1 the access happens on the accept edge itself, before the
  // latched copy exists, so the live request fields feed the access in IDLE.
  always_comb begin
    if (state == IDLE) begin
      acc_wen   = req_wen;
      acc_uns   = req_unsigned;
      acc_size  = req_size;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_wen   = lat_wen;
      acc_uns   = lat_uns;
      acc_size  = lat_size;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
    end
  end

  // Address decode: offset, word index, byte lane (aligned down to the size).
  always_comb begin
    off       = acc_addr - BASE;
    idx       = off[IW+2:3];
    range_err = (off[63:IW+3] != '0);
    lane      = off[2:0];
    be_base   = 8'h01;
    unique case (acc_size)
      2'd0: begin lane = off[2:0];           be_base = 8'h01; end
      2'd1: begin lane = {off[2:1], 1'b0};   be_base = 8'h03; end
      2'd2: begin lane = {off[2], 2'b00};    be_base = 8'h0F; end
      2'd3: begin lane = 3'b000;             be_base = 8'hFF; end
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    unique case (acc_size)
      2'd0: misaligned = 1'b0;
      2'd1: misaligned = off[0];
      2'd2: misaligned = (off[1:0] != '0);
      2'd3: misaligned = (off[2:0] != '0);
    endcase
    acc_err = range_err | misaligned;
  end
`else
  always_comb acc_err = range_err;
`endif

  // Store lane mask/data and load extraction/extension.
  always_comb begin
    be     = be_base << lane;
    wword  = acc_wdata << {lane, 3'b000};
    rshift = mem[idx] >> {lane, 3'b000};
    ldata  = rshift;
    unique case (acc_size)
      2'd0: ldata = acc_uns ? {56'd0, rshift[7:0]}  : {{56{rshift[7]}},  rshift[7:0]};
      2'd1: ldata = acc_uns ? {48'd0, rshift[15:0]} : {{48{rshift[15]}}, rshift[15:0]};
      2'd2: ldata = acc_uns ? {32'd0, rshift[31:0]} : {{32{rshift[31]}}, rshift[31:0]};
      2'd3: ldata = rshift;
    endcase
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_nxt = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_wen    <= 1'b0;
      lat_uns    <= 1'b0;
      lat_size   <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_valid) begin
        lat_wen   <= req_wen;
        lat_uns   <= req_unsigned;
        lat_size  <= req_size;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (commit) begin
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || acc_wen) ? '0 : ldata;
      end else if (state == RESP && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Array is not reset; a commit edge that coincides with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit && acc_wen && !acc_err) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam logic [63:0] BASE    = 64'h8000_0000;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  // Expected response of one accepted request, plus its pending store.
  typedef struct {
    logic [63:0]     rd;
    bit              err;
    bit              wr;
    longint unsigned a;
    int              n;
    logic [63:0]     wdata;
    int              acc;
  } exp_t;

  exp_t        exp_q[$];
  bit [7:0]    mb [DEPTH*8];   // byte-addressed reference memory
  logic [63:0] last_rd = '0;
  logic        last_err = 1'b0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input bit wen, input logic [63:0] addr, input logic [1:0] size,
                                 input bit uns, input logic [63:0] wdata);
    exp_t        e;
    logic [63:0] off, v, rem;
    int          n;
    n     = 1 << size;
    off   = addr - BASE;
    rem   = off % 64'(n);
    e.err = (off >= 64'(DEPTH) * 64'd8);
`ifdef DMEM_ALIGN_CHECK_EN
    if (rem != 64'd0) e.err = 1'b1;
`endif
    e.a     = off - rem;
    e.n     = n;
    e.wdata = wdata;
    e.wr    = wen && !e.err;
    e.rd    = '0;
    e.acc   = 0;
    if (!e.err && !wen) begin
      v = '0;
      for (int i = 0; i < n; i++) v |= 64'(mb[e.a + longint'(i)]) << (8 * i);
      if (!uns && n < 8 && v[8*n-1]) v |= ~64'd0 << (8 * n);
      e.rd = v;
    end
    return e;
  endfunction

  // Cycle-by-cycle comparison of the handshake outputs against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() == 0) begin
        check64("idle_req_ready", 64'(req_ready), 64'd1);
        check64("idle_resp_valid", 64'(resp_valid), 64'd0);
      end else begin
        check64("busy_req_ready", 64'(req_ready), 64'd0);
        check64("resp_valid_timing", 64'(resp_valid),
                64'((cyc - exp_q[0].acc + 1) >= int'(LATENCY)));
        if (resp_valid) begin
          check64("resp_rdata", resp_rdata, exp_q[0].rd);
          check64("resp_err", 64'(resp_err), 64'(exp_q[0].err));
          if (resp_ready) begin
            last_rd  = resp_rdata;
            last_err = resp_err;
            if (exp_q[0].wr)
              for (int i = 0; i < exp_q[0].n; i++)
                mb[exp_q[0].a + longint'(i)] = exp_q[0].wdata[8*i +: 8];
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit wen, input logic [63:0] addr, input logic [1:0] size,
                       input bit uns, input logic [63:0] wdata);
    exp_t e;
    int   n = 0;
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    while (!req_ready && n < 20) begin tick; n++; end
    check64("accept_ready", 64'(req_ready), 64'd1);
    e = model(wen, addr, size, uns, wdata);
    tick;
    e.acc = cyc;
    exp_q.push_back(e);
    // Garbage on the request bus must not disturb the latched request.
    req_valid    = 1'b0;
    req_wen      = 1'($urandom);
    req_addr     = {$urandom, $urandom};
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_wdata    = {$urandom, $urandom};
  endtask

  task automatic xact(input bit wen, input logic [63:0] addr, input logic [1:0] size,
                      input bit uns, input logic [63:0] wdata, input int hold, input bit early);
    int n = 0;
    issue(wen, addr, size, uns, wdata);
    if (early) resp_ready = 1'b1;
    while (!resp_valid && n < 50) begin tick; n++; end
    check64("resp_wait", 64'(resp_valid), 64'd1);
    if (!early) begin
      repeat (hold) tick;
      resp_ready = 1'b1;
    end
    tick;
    resp_ready = 1'b0;
  endtask

  task automatic abort(input bit wen, input logic [63:0] addr, input logic [1:0] size,
                       input logic [63:0] wdata, input bit in_resp);
    int n = 0;
    issue(wen, addr, size, 1'b0, wdata);
    if (in_resp) while (!resp_valid && n < 50) begin tick; n++; end
    rst = 1'b1;
    tick;
    exp_q.delete();
    rst = 1'b0;
    check64("abort_req_ready", 64'(req_ready), 64'd1);
    check64("abort_resp_valid", 64'(resp_valid), 64'd0);
    check64("abort_resp_rdata", resp_rdata, 64'd0);
    check64("abort_resp_err", 64'(resp_err), 64'd0);
  endtask

  task automatic lit(input string name, input logic [63:0] rd, input bit err);
    check64({name, "_rdata"}, last_rd, rd);
    check64({name, "_err"}, 64'(last_err), 64'(err));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    repeat (3) tick;
    rst = 1'b0;
    check64("reset_req_ready", 64'(req_ready), 64'd1);
    check64("reset_resp_valid", 64'(resp_valid), 64'd0);
    check64("reset_resp_rdata", resp_rdata, 64'd0);
    check64("reset_resp_err", 64'(resp_err), 64'd0);

    xact(1, BASE, 2'd3, 0, 64'h1122_3344_5566_7788, 0, 0);
    lit("st_d", 64'd0, 0);
    xact(0, BASE, 2'd3, 0, 64'd0, 0, 0);
    lit("ld_d", 64'h1122_3344_5566_7788, 0);

    xact(1, BASE + 3, 2'd0, 0, 64'hFFFF_FFFF_FFFF_FFAB, 0, 0);
    xact(0, BASE, 2'd2, 0, 64'd0, 0, 0);
    lit("ld_w_s", 64'hFFFF_FFFF_AB66_7788, 0);
    xact(0, BASE, 2'd2, 1, 64'd0, 0, 0);
    lit("ld_w_u", 64'h0000_0000_AB66_7788, 0);
    xact(0, BASE + 6, 2'd1, 0, 64'd0, 0, 0);
    lit("ld_h_s", 64'h0000_0000_0000_1122, 0);
    xact(0, BASE + 3, 2'd0, 0, 64'd0, 0, 0);
    lit("ld_b_s", 64'hFFFF_FFFF_FFFF_FFAB, 0);

    xact(0, 64'h7FFF_FFF8, 2'd3, 0, 64'd0, 0, 0);
    lit("ld_below", 64'd0, 1);
    xact(0, BASE + DEPTH * 8, 2'd3, 0, 64'd0, 0, 0);
    lit("ld_above", 64'd0, 1);
    xact(1, BASE + DEPTH * 8, 2'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    lit("st_above", 64'd0, 1);
    xact(0, BASE, 2'd3, 0, 64'd0, 0, 0);
    lit("word0_kept", 64'h1122_3344_AB66_7788, 0);

    xact(1, BASE + DEPTH * 8 - 8, 2'd3, 0, 64'hCAFE_F00D_1234_5678, 0, 0);
    xact(0, BASE + DEPTH * 8 - 2, 2'd1, 1, 64'd0, 0, 0);
    lit("ld_top_h", 64'h0000_0000_0000_CAFE, 0);

    xact(0, BASE, 2'd3, 0, 64'd0, 5, 0);
    lit("ld_hold", 64'h1122_3344_AB66_7788, 0);
    xact(0, BASE + 3, 2'd0, 1, 64'd0, 0, 1);
    lit("ld_early", 64'h0000_0000_0000_00AB, 0);

    xact(1, BASE + 16, 2'd3, 0, 64'd0, 0, 0);
    xact(1, BASE + 18, 2'd1, 0, 64'h0001_BEEF, 0, 0);
    xact(1, BASE + 20, 2'd2, 0, 64'h89AB_CDEF, 0, 0);
    xact(0, BASE + 16, 2'd3, 0, 64'd0, 0, 0);
    lit("lanes", 64'h89AB_CDEF_BEEF_0000, 0);

    xact(1, BASE + 8, 2'd3, 0, 64'h0123_4567_89AB_CDEF, 0, 0);
    abort(1, BASE + 8, 2'd2, 64'hDEAD_BEEF, 0);
    xact(0, BASE + 8, 2'd3, 0, 64'd0, 0, 0);
    lit("after_abort", 64'h0123_4567_89AB_CDEF, 0);
    abort(0, BASE + 8, 2'd3, 64'd0, 1);

    xact(0, BASE + 2, 2'd2, 0, 64'd0, 0, 0);
    xact(1, BASE + 17, 2'd1, 0, 64'h7777, 0, 0);
    xact(0, BASE + 16, 2'd3, 0, 64'd0, 0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    lit("misalign_st", 64'h89AB_CDEF_BEEF_0000, 0);
    xact(0, BASE + 2, 2'd2, 0, 64'd0, 0, 0);
    lit("misalign_ld", 64'd0, 1);
`else
    lit("misalign_st", 64'h89AB_CDEF_BEEF_7777, 0);
    xact(0, BASE + 2, 2'd2, 0, 64'd0, 0, 0);
    lit("misalign_ld", 64'hFFFF_FFFF_AB66_7788, 0);
`endif

    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
